// File: rtl/zad8_pkg.sv
// ============================================================================
// Package : zad8_pkg
// Purpose : Shared types and constants for the Zad_8 reciprocal-to-integer
//           path. It holds the Q5.19 reciprocal type, the divider FSM state
//           encoding, the iteration count and the raw encoding of 1.0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package zad8_pkg;

  localparam int IN_INT_DEF  = 5;
  localparam int IN_FRAC_DEF = 19;
  localparam int OUT_W_DEF   = 16;

  // One quotient bit is produced per iteration. The dividend 2^(IN_FRAC+1)
  // is IN_FRAC+2 bits wide, so the divider runs that many iterations.
  localparam int NIT = IN_FRAC_DEF + 2;

  // Raw encoding of 1.0 in Q5.19.
  localparam int RECIP_ONE = 1 << IN_FRAC_DEF;

  typedef logic [4:-19] fix5_19_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } div_state_t;

endpackage : zad8_pkg

`default_nettype wire

// File: rtl/zad_8_2_recip_to_int_fixed_udiv_seq.sv
// ============================================================================
// Module  : fixed_udiv_seq
// Purpose : Generic unsigned restoring divider that produces one quotient bit
//           per clock. A load pulse captures the operands. The core then runs
//           DVD_W iterations, and done_o is high during the cycle whose
//           closing edge performs the final iteration.
// Ports   : clk, rst        - clock, synchronous active-high reset
//           load_i          - capture dividend/divisor and start iterating
//           dividend_i      - DVD_W-bit unsigned dividend
//           divisor_i       - DVS_W-bit unsigned divisor
//           busy_o          - iterations in progress
//           done_o          - the final iteration happens on the next edge
//           quotient_o      - quotient (valid once busy_o has dropped)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_udiv_seq #(
  parameter int DVD_W = 21,
  parameter int DVS_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CNT_W = $clog2(DVD_W);

  // The remainder is always below the divisor, so DVS_W bits hold it.
  // The shifted trial value needs one extra bit so the compare never wraps.
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;  // dividend bits shift out, quotient bits shift in
  logic [DVS_W-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [DVS_W:0]   rem_sh;
  logic             ge;

  always_comb begin
    rem_sh = {rem_q, quo_q[DVD_W-1]};
    ge     = (rem_sh >= {1'b0, dvs_q});
    rem_d  = ge ? DVS_W'(rem_sh - {1'b0, dvs_q}) : rem_sh[DVS_W-1:0];
    quo_d  = {quo_q[DVD_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (load_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= CNT_W'(DVD_W - 1);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = busy_q && (cnt_q == '0);
  assign quotient_o = quo_q;

endmodule : fixed_udiv_seq

`default_nettype wire

// File: rtl/zad_8_2_recip_to_int.sv
// ============================================================================
// Module  : zad_8_2_recip_to_int
// Purpose : Maps a Q5.19 unsigned reciprocal y back to n = round(1/y).
//           It computes q = floor(2^20 / raw), then n = (q+1) >> 1, which
//           rounds 2^19/raw half-up. A result above 2^OUT_W-1, or a zero
//           input, gives all-ones with the sat flag set. Latency is fixed at
//           22 clocks from the accept edge to the ready cycle.
// Ports   : clk, rst   - clock, synchronous active-high reset
//           start      - request, sampled only while idle
//           input0     - Q5.19 reciprocal, captured on the accept edge
//           ready      - one-cycle pulse when output0/sat are updated
//           output0    - rounded integer, held until the next ready
//           sat        - output0 clipped to all-ones
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zad_8_2_recip_to_int
  import zad8_pkg::*;
#(
  parameter int IN_INT  = IN_INT_DEF,
  parameter int IN_FRAC = IN_FRAC_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_INT-1:-IN_FRAC]  input0,
  output logic                      ready,
  output logic [OUT_W-1:0]          output0,
  output logic                      sat
);

  localparam int IN_W  = IN_INT + IN_FRAC;
  localparam int DVD_W = IN_FRAC + 2;
  // Dividend is 2.0 in the input's scaling. Dividing by 2 after rounding
  // turns the result into round(1.0 / y).
  localparam logic [DVD_W-1:0] DIVIDEND = {1'b1, {(DVD_W-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic             zero_q, zero_d;
  logic             ready_q, ready_d;
  logic [OUT_W-1:0] output0_q, output0_d;
  logic             sat_q, sat_d;
  logic             load;
  logic             div_busy;
  logic             div_done;
  logic [DVD_W-1:0] quotient;
  logic [DVD_W-1:0] rounded;
  logic             ovf;

  // The core also runs for a zero input, which keeps the latency
  // data-independent. Its quotient is discarded because zero_q forces
  // the saturated result.
  fixed_udiv_seq #(
    .DVD_W (DVD_W),
    .DVS_W (IN_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .dividend_i (DIVIDEND),
    .divisor_i  (input0),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  always_comb begin
    rounded = DVD_W'(({1'b0, quotient} + (DVD_W+1)'(1)) >> 1);
    ovf     = |rounded[DVD_W-1:OUT_W];
  end

  always_comb begin
    state_d   = state_q;
    zero_d    = zero_q;
    ready_d   = 1'b0;
    output0_d = output0_q;
    sat_d     = sat_q;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          zero_d  = (input0 == '0);
          state_d = DIV;
        end
      end
      DIV: begin
        if (div_done && div_busy) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        ready_d = 1'b1;
        if (zero_q || ovf) begin
          output0_d = '1;
          sat_d     = 1'b1;
        end else begin
          output0_d = rounded[OUT_W-1:0];
          sat_d     = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      zero_q    <= 1'b0;
      ready_q   <= 1'b0;
      output0_q <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      zero_q    <= zero_d;
      ready_q   <= ready_d;
      output0_q <= output0_d;
      sat_q     <= sat_d;
    end
  end

  assign ready   = ready_q;
  assign output0 = output0_q;
  assign sat     = sat_q;

endmodule : zad_8_2_recip_to_int

`default_nettype wire

// File: tb/tb_zad_8_2_recip_to_int.sv
// ============================================================================
// Module  : tb_zad_8_2_recip_to_int
// Purpose : Self-checking bench for zad_8_2_recip_to_int. Expected results
//           come from round(2^19/raw), computed with plain integer
//           arithmetic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_zad_8_2_recip_to_int;
  import zad8_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  fix5_19_t    input0;
  logic        ready;
  logic [15:0] output0;
  logic        sat;

  int n_checks;
  int n_pass;

  zad_8_2_recip_to_int dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .input0  (input0),
    .ready   (ready),
    .output0 (output0),
    .sat     (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-half-up of 2^19/raw, i.e. floor((2^20 + raw) / (2*raw)).
  function automatic void model(input logic [23:0] raw,
                                output logic [15:0] n, output logic s);
    longint q;
    if (raw == 24'd0) begin
      n = 16'hFFFF;
      s = 1'b1;
    end else begin
      q = ((longint'(1) << 20) + longint'(raw)) / (2 * longint'(raw));
      if (q > 65535) begin
        n = 16'hFFFF;
        s = 1'b1;
      end else begin
        n = q[15:0];
        s = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait for ready with a bound, then check the latency
  // and the result against the model.
  task automatic do_op(input logic [23:0] raw, input string tag);
    logic [15:0] en;
    logic        es;
    int          k;
    model(raw, en, es);
    start  = 1'b1;
    input0 = raw;
    tick();               // accept edge
    start  = 1'b0;
    k = 0;
    do begin
      tick();
      k++;
    end while (!ready && k < 40);
    chk({tag, "_latency"}, 32'(k), 32'd22);
    chk({tag, "_out"}, 32'(output0), 32'(en));
    chk({tag, "_sat"}, 32'(sat), 32'(es));
    tick();
    chk({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    chk({tag, "_out_held"}, 32'(output0), 32'(en));
  endtask

  initial begin
    logic [23:0] r;
    logic [15:0] en;
    logic        es;
    int          k;
    int          nrdy;

    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    input0   = '0;

    // Reset state
    tick();
    tick();
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_out", 32'(output0), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);
    rst = 1'b0;
    tick();

    // Directed values
    do_op(24'h080000, "one");
    do_op(24'h02AAAA, "third");
    do_op(24'h100000, "two_half");
    do_op(24'hFFFFFF, "max_in");
    do_op(24'h000000, "zero");
    do_op(24'h000001, "raw1");
    do_op(24'h000008, "raw8");
    do_op(24'h000009, "raw9");
    chk("raw9_literal", 32'(output0), 32'd58254);

    // Randomized values spanning saturation, small and large inputs
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       r = 24'($urandom_range(1, 200));
        1:       r = 24'($urandom_range(8, 70000));
        default: r = 24'($urandom);
      endcase
      do_op(r, "rand");
    end

    // Reset during DIV aborts the operation
    start  = 1'b1;
    input0 = 24'h000009;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready_a", 32'(ready), 32'd0);
    chk("midrst_out_a", 32'(output0), 32'd0);
    tick();
    chk("midrst_ready_b", 32'(ready), 32'd0);
    chk("midrst_out_b", 32'(output0), 32'd0);
    rst  = 1'b0;
    nrdy = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready) nrdy++;
    end
    chk("midrst_no_ready", 32'(nrdy), 32'd0);
    do_op(24'h080000, "after_rst");

    // start held high through DIV while input0 toggles
    r = 24'h02AAAA;
    model(r, en, es);
    start  = 1'b1;
    input0 = r;
    tick();
    k = 0;
    do begin
      input0 = 24'($urandom);
      tick();
      k++;
    end while (!ready && k < 40);
    start = 1'b0;
    chk("hold_latency", 32'(k), 32'd22);
    chk("hold_out", 32'(output0), 32'(en));
    chk("hold_sat", 32'(sat), 32'(es));
    nrdy = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ready) nrdy++;
    end
    chk("hold_single_result", 32'(nrdy), 32'd0);

    // Self-handshake loop: start follows ready, n = 1..512
    r = 24'(((longint'(1) << 20) + 1) / 2);
    start  = 1'b1;
    input0 = r;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 512; n++) begin
      k = 0;
      do begin
        tick();
        k++;
      end while (!ready && k < 40);
      chk("loop_period", 32'(k + 1), 32'd23);
      chk("loop_out", 32'(output0), 32'(n));
      if (n < 512) begin
        r = 24'(((longint'(1) << 20) + longint'(n + 1)) / (2 * longint'(n + 1)));
        input0 = r;
        start  = 1'b1;
      end
      tick();
      start = 1'b0;
      chk("loop_ready_pulse", 32'(ready), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_zad_8_2_recip_to_int

`default_nettype wire
